// File: rtl/pipe_flush_ctrl.sv
// Pipeline flush/stall controller.
// Turns redirect requests and stall conditions into per-boundary clear and load
// enables, plus the PC load enable. A flush squashes the youngest boundaries
// for FLUSH_CYCLES unstalled cycles. A memory stall defers the flush but does
// not drop it. The outputs are a pure decode of the current state and inputs.
module pipe_flush_ctrl #(
   parameter int NUM_BOUND    = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int DW           = $clog2(NUM_BOUND + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [DW-1:0]        flush_depth,
   input  logic                 hazard_stall,
   input  logic                 mem_stall,
   output logic [NUM_BOUND-1:0] flush_vec,
   output logic [NUM_BOUND-1:0] load_vec,
   output logic                 pc_load,
   output logic                 busy
);

   typedef enum logic {IDLE, FLUSHING} state_t;

   localparam logic [3:0] FC = FLUSH_CYCLES[3:0];

   state_t               state;
   logic [3:0]           cnt;
   logic [NUM_BOUND-1:0] mask;
   logic [NUM_BOUND-1:0] mask_new;

   // Thermometer mask of the youngest boundaries.
   // A depth of 0 still squashes IF_ID, and depths past the last boundary saturate.
   function automatic logic [NUM_BOUND-1:0] depth_mask(input logic [DW-1:0] depth);
      int                   d;
      logic [NUM_BOUND-1:0] m;
      d = int'(depth);
      if (d < 1)
         d = 1;
      if (d > NUM_BOUND)
         d = NUM_BOUND;
      m = '0;
      for (int i = 0; i < NUM_BOUND; i++)
         m[i] = (i < d);
      return m;
   endfunction

   assign mask_new = depth_mask(flush_depth);

   // Flush sequencer.
   // A new request restarts the count and widens the mask. A memory stall
   // freezes the countdown, but a flush request is still accepted during it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mask  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  state <= FLUSHING;
                  cnt   <= FC;
                  mask  <= mask_new;
               end
            end
            FLUSHING: begin
               if (flush) begin
                  cnt  <= FC;
                  mask <= mask | mask_new;
               end else if (!mem_stall) begin
                  if (cnt == 4'd1) begin
                     state <= IDLE;
                     cnt   <= '0;
                     mask  <= '0;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode, in priority order: reset, memory stall, flushing, load-use hazard, normal.
   always_comb begin
      flush_vec = '0;
      load_vec  = '1;
      pc_load   = 1'b1;
      busy      = (state == FLUSHING);
      if (rst) begin
         busy = 1'b0;
      end else if (mem_stall) begin
         load_vec = '0;
         pc_load  = 1'b0;
      end else if (state == FLUSHING) begin
         flush_vec = mask;
      end else if (hazard_stall) begin
         pc_load      = 1'b0;
         load_vec[0]  = 1'b0;
         flush_vec[1] = 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Scoreboard bench for pipe_flush_ctrl.
// The driver applies one directed vector per cycle and queues the outputs it
// expects for that cycle. Per-DUT monitors pop the queue and compare on the falling edge.
module tb_pipe_flush_ctrl;

   typedef struct {
      logic [7:0] fv;
      logic [7:0] lv;
      logic       pc;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       flush_a = 1'b0, hz_a = 1'b0, ms_a = 1'b0;
   logic [2:0] depth_a = '0;
   logic [3:0] fv_a, lv_a;
   logic       pc_a, busy_a;

   logic       flush_b = 1'b0, hz_b = 1'b0, ms_b = 1'b0;
   logic [3:0] depth_b = '0;
   logic [7:0] fv_b, lv_b;
   logic       pc_b, busy_b;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_flush_ctrl dut_a (
      .clk(clk), .rst(rst), .flush(flush_a), .flush_depth(depth_a),
      .hazard_stall(hz_a), .mem_stall(ms_a),
      .flush_vec(fv_a), .load_vec(lv_a), .pc_load(pc_a), .busy(busy_a)
   );

   pipe_flush_ctrl #(.NUM_BOUND(8), .FLUSH_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .flush(flush_b), .flush_depth(depth_b),
      .hazard_stall(hz_b), .mem_stall(ms_b),
      .flush_vec(fv_b), .load_vec(lv_b), .pc_load(pc_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor for the default configuration.
   always @(negedge clk) begin
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         check("a_flush_vec", {4'b0, fv_a}, ea.fv);
         check("a_load_vec",  {4'b0, lv_a}, ea.lv);
         check("a_pc_load",   {7'b0, pc_a}, {7'b0, ea.pc});
         check("a_busy",      {7'b0, busy_a}, {7'b0, ea.busy});
      end
   end

   // Monitor for the 8-boundary, single-cycle configuration.
   always @(negedge clk) begin
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         check("b_flush_vec", fv_b, eb.fv);
         check("b_load_vec",  lv_b, eb.lv);
         check("b_pc_load",   {7'b0, pc_b}, {7'b0, eb.pc});
         check("b_busy",      {7'b0, busy_b}, {7'b0, eb.busy});
      end
   end

   // One cycle of stimulus for dut_a.
   // Inputs change just after the rising edge. An optional reset pulse falls
   // entirely between two clock edges.
   task automatic step_a(input logic r, input logic pulse, input logic fl, input logic [2:0] d,
                         input logic hz, input logic ms,
                         input logic [3:0] fv, input logic [3:0] lv, input logic pc, input logic bz);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; flush_a = fl; depth_a = d; hz_a = hz; ms_a = ms;
      if (pulse) begin
         #1 rst = 1'b1;
         #1 rst = 1'b0;
      end
      e.fv = {4'b0, fv}; e.lv = {4'b0, lv}; e.pc = pc; e.busy = bz;
      qa.push_back(e);
   endtask

   // One cycle of stimulus for dut_b.
   task automatic step_b(input logic fl, input logic [3:0] d, input logic hz,
                         input logic [7:0] fv, input logic [7:0] lv, input logic pc, input logic bz);
      exp_t e;
      @(posedge clk);
      #1;
      flush_b = fl; depth_b = d; hz_b = hz; ms_b = 1'b0;
      e.fv = fv; e.lv = lv; e.pc = pc; e.busy = bz;
      qb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // While reset is held, the outputs are forced even with every input active.
      step_a(1, 0, 1, 3'd4, 1, 1, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);

      // Basic flush of depth 2.
      step_a(0, 0, 1, 3'd2, 0, 0, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0011, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0011, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);

      // Memory stall for 3 cycles in the middle of a flush.
      step_a(0, 0, 1, 3'd2, 0, 0, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 0, 0, 3'd0, 0, 1, 4'b0000, 4'b0000, 0, 1);
      step_a(0, 0, 0, 3'd0, 0, 1, 4'b0000, 4'b0000, 0, 1);
      step_a(0, 0, 0, 3'd0, 0, 1, 4'b0000, 4'b0000, 0, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0011, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0011, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);

      // A flush requested during a memory stall in IDLE is still accepted.
      // A depth of 0 squashes only IF_ID.
      step_a(0, 0, 1, 3'd0, 1, 1, 4'b0000, 4'b0000, 0, 0);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0001, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0001, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);

      // A second flush one cycle later restarts the count and widens the mask.
      step_a(0, 0, 1, 3'd1, 0, 0, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 0, 1, 3'd3, 0, 0, 4'b0001, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0111, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0111, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);

      // Load-use hazard decodes in IDLE and is ignored while flushing.
      step_a(0, 0, 0, 3'd0, 1, 0, 4'b0010, 4'b1110, 0, 0);
      step_a(0, 0, 1, 3'd4, 1, 0, 4'b0010, 4'b1110, 0, 0);
      step_a(0, 0, 0, 3'd0, 1, 0, 4'b1111, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 1, 0, 4'b1111, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 1, 0, 4'b0010, 4'b1110, 0, 0);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);

      // A reset pulse between clock edges abandons the flush at once.
      // The next flush then runs a full sequence.
      step_a(0, 0, 1, 3'd2, 0, 0, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 1, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 0, 1, 3'd2, 0, 0, 4'b0000, 4'b1111, 1, 0);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0011, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0011, 4'b1111, 1, 1);
      step_a(0, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b1111, 1, 0);

      // Eight boundaries with single-cycle flushes: the depth saturates, and 0 selects IF_ID.
      step_b(1, 4'd15, 0, 8'h00, 8'hFF, 1, 0);
      step_b(0, 4'd0,  0, 8'hFF, 8'hFF, 1, 1);
      step_b(0, 4'd0,  0, 8'h00, 8'hFF, 1, 0);
      step_b(1, 4'd0,  0, 8'h00, 8'hFF, 1, 0);
      step_b(0, 4'd0,  0, 8'h01, 8'hFF, 1, 1);
      step_b(0, 4'd0,  0, 8'h00, 8'hFF, 1, 0);
      step_b(0, 4'd0,  1, 8'h02, 8'hFE, 0, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      check("queues_drained", 8'(qa.size() + qb.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_flush_ctrl.md
PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

Interface
REQ-001 Parameter NUM_BOUND, default 4: number of pipeline register boundaries; index 0 = IF_ID, 1 = ID_EX, 2 = EX_MEM, 3 = MEM_WB; legal range 2..8.
REQ-002 Parameter FLUSH_CYCLES, default 2: number of unstalled cycles a flush stays asserted; legal range 1..15.
REQ-003 Parameter DW, derived as $clog2(NUM_BOUND+1): width of flush_depth.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  redirect request (branch, jump or trap resolved); sampled every cycle.
REQ-007 flush_depth  in  DW  number of youngest boundaries to squash, counted from index 0.
REQ-008 hazard_stall  in  1  load-use hazard: freeze PC and IF_ID, bubble into ID_EX.
REQ-009 mem_stall  in  1  global memory stall: freeze every boundary.
REQ-010 flush_vec  out  NUM_BOUND  per-boundary synchronous clear (insert NOP).
REQ-011 load_vec  out  NUM_BOUND  per-boundary load enable.
REQ-012 pc_load  out  1  PC register load enable.
REQ-013 busy  out  1  high while a flush sequence is active.

Function
REQ-014 FSM states: IDLE and FLUSHING. Internal state also holds counter cnt (4 bits) and mask (NUM_BOUND bits).
REQ-015 Mask computation: mask_new = (1 << d) - 1, where d = flush_depth clamped to 1..NUM_BOUND (0 is treated as 1; values above NUM_BOUND saturate).
REQ-016 When flush = 1 in IDLE: next state is FLUSHING, cnt <= FLUSH_CYCLES, mask <= mask_new. This holds even when mem_stall = 1.
REQ-017 When flush = 1 in FLUSHING: cnt reloads to FLUSH_CYCLES and mask <= mask | mask_new (restart and widen).
REQ-018 In FLUSHING with flush = 0 and mem_stall = 0: cnt decrements by 1; when cnt == 1, next state is IDLE and mask <= 0.
REQ-019 In FLUSHING with mem_stall = 1 and flush = 0: cnt and mask hold.
REQ-020 Flush latency: flush_vec first asserts in the cycle after flush is sampled, and stays asserted for exactly FLUSH_CYCLES unstalled cycles.
REQ-021 Output priority: rst > mem_stall > FLUSHING > hazard_stall > normal.
REQ-022 mem_stall = 1: flush_vec = 0, load_vec = 0, pc_load = 0. Flush pulses are deferred, not lost.
REQ-023 FLUSHING with mem_stall = 0: flush_vec = mask, load_vec = all ones, pc_load = 1. hazard_stall is ignored in this state.
REQ-024 IDLE with hazard_stall = 1 and mem_stall = 0:
  - pc_load = 0.
  - load_vec[0] = 0; all other load_vec bits = 1.
  - flush_vec[1] = 1; all other flush_vec bits = 0.
REQ-025 IDLE with no stall: flush_vec = 0, load_vec = all ones, pc_load = 1.
REQ-026 busy = 1 exactly when state == FLUSHING.
REQ-027 All outputs are combinational decodes of state, cnt, mask, mem_stall, hazard_stall and rst; there is no output register.

Reset
REQ-028 On rst assertion, without waiting for a clock edge: state <= IDLE, cnt <= 0, mask <= 0.
REQ-029 While rst = 1, outputs are forced regardless of other inputs: flush_vec = 0, load_vec = all ones, pc_load = 1, busy = 0.
REQ-030 Reset mid-flush abandons the sequence. The first edge after rst deasserts evaluates from IDLE.
REQ-031 A flush sampled on the same edge as rst deassertion is honoured.

Verification
REQ-032 Defaults, flush = 1 for one cycle with flush_depth = 2 -> flush_vec = 4'b0011 for exactly 2 cycles, busy = 1 for the same 2 cycles, then flush_vec = 0 and busy = 0.
REQ-033 Flush accepted, then mem_stall = 1 for 3 cycles during FLUSHING -> flush_vec = 0, load_vec = 0, pc_load = 0 during the stall; after the stall, flush_vec = mask for the remaining cycles, so the total count of asserted cycles = 2.
REQ-034 flush_depth = 1, then a second flush with flush_depth = 3 one cycle later -> flush_vec becomes 4'b0111 and is held for 2 further cycles after the second flush.
REQ-035 hazard_stall = 1 in IDLE -> pc_load = 0, load_vec = 4'b1110, flush_vec = 4'b0010. The same stimulus during FLUSHING -> hazard_stall is ignored.
REQ-036 rst pulsed asynchronously (between clock edges) mid-FLUSHING -> busy = 0 and flush_vec = 0 immediately; the next flush restarts a full 2-cycle sequence.
REQ-037 NUM_BOUND = 8, FLUSH_CYCLES = 1, flush_depth = 15 -> flush_vec = 8'hFF for 1 cycle (depth saturates); flush_depth = 0 -> flush_vec = 8'h01.
